// File: rtl/er_exec_reporter.sv
// ER pass tracker: turns the EXEC flag into a pass verdict plus a saturating pass count, read out via a req/ack snapshot.
// Optional: ER_EXEC_REPORTER_CLEAR_ON_READ_EN clears the count and returns DONE to IDLE on each snapshot capture.
module er_exec_reporter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      pc,
    input  logic             exec,
    input  logic [15:0]      ER_min,
    input  logic [15:0]      ER_max,
    input  logic             snap_req,
    output logic             snap_ack,
    output logic             snap_exec,
    output logic [CNT_W-1:0] snap_count,
    output logic             er_active
);

    typedef enum logic [1:0] {IDLE, RUN, DONE, FAIL} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             in_er;
    logic             capture;
    logic             pass_done;

    always_comb begin
        in_er   = (pc >= ER_min) && (pc <= ER_max);
        capture = snap_req && !snap_ack;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pass_done = 1'b0;
        case (state)
            RUN: begin
                // exec loss dominates; reaching ER_max wins over the range check
                if (!exec) begin
                    state_nxt = FAIL;
                end else if (pc == ER_max) begin
                    state_nxt = DONE;
                    pass_done = 1'b1;
                end else if (!in_er) begin
                    state_nxt = FAIL;
                end
            end
            default: begin
                if (pc == ER_min) begin
                    state_nxt = exec ? RUN : FAIL;
                end
            end
        endcase

        count_nxt = count;
        if (pass_done && (count != CNT_MAX)) begin
            count_nxt = count + 1'b1;
        end

`ifdef ER_EXEC_REPORTER_CLEAR_ON_READ_EN
        // A read consumes the verdict, including one completing on this very edge
        if (capture) begin
            count_nxt = '0;
            if (state_nxt == DONE) begin
                state_nxt = IDLE;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_ack   <= 1'b0;
            snap_exec  <= 1'b0;
            snap_count <= '0;
        end else if (capture) begin
            snap_ack   <= 1'b1;
            snap_exec  <= (state == DONE);
            snap_count <= count;
        end else if (!snap_req) begin
            snap_ack   <= 1'b0;
        end
    end

    always_comb begin
        er_active = (state == RUN);
    end

endmodule

// File: tb/tb_er_exec_reporter.sv
// Bench for er_exec_reporter: pass-level reference model checked every cycle, plus hand-computed snapshot literals.
module tb_er_exec_reporter;

    localparam int CW   = 2;
    localparam int MAXC = (1 << CW) - 1;
`ifdef ER_EXEC_REPORTER_CLEAR_ON_READ_EN
    localparam bit COR = 1'b1;
`else
    localparam bit COR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   pc;
    logic          exec;
    logic [15:0]   ER_min;
    logic [15:0]   ER_max;
    logic          snap_req;
    logic          snap_ack;
    logic          snap_exec;
    logic [CW-1:0] snap_count;
    logic          er_active;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;
    bit act_en = 1'b0;
    int act_cycles = 0;

    // Reference model: "inside a pass" plus "last pass ended at ER_max"
    bit m_in_pass = 1'b0;
    bit m_last_ok = 1'b0;
    int m_count = 0;
    bit m_ack = 1'b0;
    bit m_sexec = 1'b0;
    int m_scount = 0;
    bit cap;

    er_exec_reporter #(.CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .exec       (exec),
        .ER_min     (ER_min),
        .ER_max     (ER_max),
        .snap_req   (snap_req),
        .snap_ack   (snap_ack),
        .snap_exec  (snap_exec),
        .snap_count (snap_count),
        .er_active  (er_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_in_pass = 1'b0;
            m_last_ok = 1'b0;
            m_count   = 0;
            m_ack     = 1'b0;
            m_sexec   = 1'b0;
            m_scount  = 0;
        end else begin
            cap = snap_req && !m_ack;
            if (cap) begin
                m_sexec  = m_last_ok;
                m_scount = m_count;
                m_ack    = 1'b1;
            end else if (!snap_req) begin
                m_ack = 1'b0;
            end
            if (m_in_pass) begin
                if (!exec) begin
                    m_in_pass = 1'b0;
                    m_last_ok = 1'b0;
                end else if (pc == ER_max) begin
                    m_in_pass = 1'b0;
                    m_last_ok = 1'b1;
                    if (m_count < MAXC) m_count++;
                end else if (pc < ER_min || pc > ER_max) begin
                    m_in_pass = 1'b0;
                end
            end else if (pc == ER_min) begin
                m_in_pass = exec;
                m_last_ok = 1'b0;
            end
            if (COR && cap) begin
                m_count   = 0;
                m_last_ok = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (started && !reset) begin
            chk("er_active", er_active, m_in_pass);
            chk("snap_ack", snap_ack, m_ack);
            chk("snap_exec", snap_exec, m_sexec);
            chk("snap_count", snap_count, m_scount);
            if (act_en && er_active) act_cycles++;
        end
    end

    task automatic step(input logic [15:0] p, input logic ex);
        @(negedge clk);
        pc   = p;
        exec = ex;
    endtask

    task automatic walk(input int a, input int b);
        for (int p = a; p <= b; p++) step(p[15:0], 1'b1);
    endtask

    task automatic snapshot(input string tag, input logic e, input int c);
        @(negedge clk);
        snap_req = 1'b1;
        @(negedge clk);
        chk({tag, "_ack1"}, snap_ack, 1);
        chk({tag, "_exec"}, snap_exec, e);
        chk({tag, "_count"}, snap_count, c);
        snap_req = 1'b0;
        @(negedge clk);
        chk({tag, "_ack0"}, snap_ack, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; pc = '0; exec = 1'b0; snap_req = 1'b0;
        ER_min = 16'hE000; ER_max = 16'hE010;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_active", er_active, 0);
        chk("rst_ack", snap_ack, 0);
        chk("rst_exec", snap_exec, 0);
        chk("rst_count", snap_count, 0);
        @(negedge clk); #2 reset = 1'b0;
        started = 1'b1;

        // clean pass
        act_en = 1'b1;
        walk(16'hE000, 16'hE010);
        step(16'h1000, 1'b1);
        act_en = 1'b0;
        chk("er_active_cycles", act_cycles, 16);
        snapshot("clean", 1'b1, 1);

        // exec violation mid-pass
        walk(16'hE000, 16'hE007);
        step(16'hE008, 1'b0);
        step(16'h1000, 1'b1);
        snapshot("viol", 1'b0, COR ? 0 : 1);

        // early exit out of ER
        walk(16'hE000, 16'hE004);
        step(16'h4000, 1'b1);
        snapshot("early", 1'b0, COR ? 0 : 1);

        // saturation after five clean passes
        repeat (5) walk(16'hE000, 16'hE010);
        step(16'h1000, 1'b1);
        snapshot("sat", 1'b1, MAXC);

        // capture on the same edge as RUN->DONE
        walk(16'hE000, 16'hE00F);
        @(negedge clk);
        pc = 16'hE010; exec = 1'b1; snap_req = 1'b1;
        @(negedge clk);
        chk("race_ack", snap_ack, 1);
        chk("race_exec", snap_exec, 0);
        chk("race_count", snap_count, COR ? 0 : MAXC);
        snap_req = 1'b0; pc = 16'h1000;
        @(negedge clk);
        snapshot("post_race", COR ? 1'b0 : 1'b1, COR ? 0 : MAXC);

        // asynchronous reset in the middle of a pass
        walk(16'hE000, 16'hE004);
        #2 reset = 1'b1;
        #1;
        chk("rst_run_active", er_active, 0);
        chk("rst_run_ack", snap_ack, 0);
        chk("rst_run_exec", snap_exec, 0);
        chk("rst_run_count", snap_count, 0);
        @(negedge clk); #2 reset = 1'b0;

        // single-address ER: entry and exit coincide
        ER_min = 16'h2000; ER_max = 16'h2000;
        step(16'h2000, 1'b1);
        @(posedge clk); #1 chk("eq_run", er_active, 1);
        step(16'h2000, 1'b1);
        @(posedge clk); #1 chk("eq_done", er_active, 0);
        step(16'h1000, 1'b1);
        snapshot("eq", 1'b1, 1);

        // asynchronous reset while ack is high
        @(negedge clk);
        snap_req = 1'b1;
        @(negedge clk);
        chk("hs_ack_up", snap_ack, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_hs_ack", snap_ack, 0);
        chk("rst_hs_exec", snap_exec, 0);
        chk("rst_hs_count", snap_count, 0);
        chk("rst_hs_active", er_active, 0);
        snap_req = 1'b0;
        @(negedge clk); #2 reset = 1'b0;
        snapshot("after_rst", 1'b0, 0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
